// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared FSM states and width limit for the bit-serial subtractor.
package serial_sub_pkg;
  localparam int MAX_WIDTH = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub_bit_cell.sv
// sub_bit_cell: combinational 1-bit full subtractor built from two half-subtractor stages.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);
  logic w_d1, w_b1, w_b2;
  assign w_d1 = a ^ b;
  assign w_b1 = ~a & b;
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;
  assign bout = w_b1 | w_b2;
endmodule

// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial WIDTH-bit subtractor, LSB first, one shared cell.
// Define SERIAL_SUB_ZERO_FLAG_EN to add the sticky Zero result flag.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             Zero
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  generate
    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("serial_sub_ctrl: WIDTH out of range");
    end
  endgenerate
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res, r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br, r_borrow, w_d, w_bo, w_last, w_accept;
  sub_bit_cell u_cell (.a(r_a[0]), .b(r_b[0]), .bin(r_br), .d(w_d), .bout(w_bo));
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_res = w_d;
    end else begin : g_wn
      assign w_res = {w_d, r_res[WIDTH-1:1]};
    end
  endgenerate
  assign w_last   = r_cnt == CW'(WIDTH - 1);
  assign w_accept = start && r_state != RUN;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (start ? RUN : IDLE);
  end
  always_ff @(posedge clk) r_state <= rst ? IDLE : w_next;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_br     <= 1'b0;
      r_cnt    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else if (w_accept) begin
      r_a   <= A;
      r_b   <= B;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_res <= w_res;
      r_br  <= w_bo;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_diff   <= w_res;
        r_borrow <= w_bo;
      end
    end
  end
  assign busy   = r_state == RUN;
  assign done   = r_state == DONE;
  assign Diff   = r_diff;
  assign Borrow = r_borrow;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic r_nz, r_zero;
  // Sticky OR of the serial difference bits avoids a WIDTH-wide reduction.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_nz   <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_accept) begin
      r_nz <= 1'b0;
    end else if (r_state == RUN) begin
      r_nz <= r_nz | w_d;
      if (w_last) r_zero <= ~(r_nz | w_d);
    end
  end
  assign Zero = r_zero;
`endif
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: directed checks of the bit-serial subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_sub_ctrl;
  logic       clk, rst;
  logic       start, busy, done, borrow;
  logic [7:0] a, b, diff;
  logic       start1, a1, b1, busy1, done1, diff1, borrow1;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic       zero, zero1;
`endif
  int vectors = 0;
  int miscompares = 0;

  serial_sub_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a), .B(b),
    .busy(busy), .done(done), .Diff(diff), .Borrow(borrow)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .Zero(zero)
`endif
  );
  serial_sub_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    , .Zero(zero1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then watches a bounded window: lat is the observation index of the first done
  task automatic run8(input logic [7:0] av, input logic [7:0] bv,
                      output int lat, output int bc, output int dc);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; bc = 0; dc = 0;
    for (int i = 0; i < 30; i++) begin
      if (busy) bc++;
      if (done) begin
        dc++;
        if (lat < 0) lat = i;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'hA5; b = 8'h5A;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    vectors++;
    if ({busy, done, diff, borrow} !== 11'd0) begin
      miscompares++;
      $display("FAIL reset8: busy=%b done=%b diff=%h borrow=%b, want all 0", busy, done, diff, borrow);
    end
    vectors++;
    if ({busy1, done1, diff1, borrow1} !== 4'd0) begin
      miscompares++;
      $display("FAIL reset1: busy=%b done=%b diff=%b borrow=%b, want all 0", busy1, done1, diff1, borrow1);
    end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    vectors++;
    if (zero !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_zero: got %b want 0", zero);
    end
`endif
  endtask

  task automatic test_basic();
    int lat, bc, dc;
    run8(8'h5A, 8'h3C, lat, bc, dc);
    vectors++;
    if (lat !== 8) begin
      miscompares++;
      $display("FAIL basic_latency: done at obs %0d want 8", lat);
    end
    vectors++;
    if (bc !== 8) begin
      miscompares++;
      $display("FAIL basic_busy: busy cycles %0d want 8", bc);
    end
    vectors++;
    if (dc !== 1) begin
      miscompares++;
      $display("FAIL basic_done_count: %0d want 1", dc);
    end
    vectors++;
    if ({diff, borrow} !== {8'h1E, 1'b0}) begin
      miscompares++;
      $display("FAIL basic_result: diff=%h borrow=%b want 1e/0", diff, borrow);
    end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    vectors++;
    if (zero !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_zero: got %b want 0", zero);
    end
`endif
  endtask

  task automatic test_underflow();
    int lat, bc, dc;
    run8(8'h00, 8'h01, lat, bc, dc);
    vectors++;
    if ({diff, borrow} !== {8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow: diff=%h borrow=%b want ff/1", diff, borrow);
    end
    run8(8'h77, 8'h77, lat, bc, dc);
    vectors++;
    if ({diff, borrow} !== {8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL equal: diff=%h borrow=%b want 00/0", diff, borrow);
    end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    vectors++;
    if (zero !== 1'b1) begin
      miscompares++;
      $display("FAIL equal_zero: got %b want 1", zero);
    end
`endif
  endtask

  task automatic test_ignore_start();
    int dc = 0;
    a = 8'h10; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (done) dc++;
      tick();
    end
    vectors++;
    if (dc !== 1) begin
      miscompares++;
      $display("FAIL ignore_done_count: %0d want 1", dc);
    end
    vectors++;
    if ({diff, borrow} !== {8'h0F, 1'b0}) begin
      miscompares++;
      $display("FAIL ignore_result: diff=%h borrow=%b want 0f/0", diff, borrow);
    end
  endtask

  task automatic test_reset_midrun();
    int lat, bc, dc = 0;
    a = 8'hF0; b = 8'h0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, done, diff, borrow} !== 11'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: busy=%b done=%b diff=%h borrow=%b want all 0", busy, done, diff, borrow);
    end
    for (int i = 0; i < 15; i++) begin
      if (done) dc++;
      tick();
    end
    vectors++;
    if (dc !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_done: %0d done pulses want 0", dc);
    end
    run8(8'h20, 8'h05, lat, bc, dc);
    vectors++;
    if ({diff, borrow, 4'(lat)} !== {8'h1B, 1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL after_reset_run: diff=%h borrow=%b lat=%0d want 1b/0/8", diff, borrow, lat);
    end
  endtask

  task automatic test_back_to_back();
    int t0 = -1, t1 = -1;
    logic [8:0] r0 = '0, r1 = '0;
    a = 8'h09; b = 8'h03; start = 1'b1;
    tick();
    for (int i = 0; i < 40 && t1 < 0; i++) begin
      if (i == 0) begin a = 8'h03; b = 8'h09; end
      if (done) begin
        if (t0 < 0) begin t0 = i; r0 = {diff, borrow}; end
        else begin t1 = i; r1 = {diff, borrow}; start = 1'b0; end
      end
      tick();
    end
    start = 1'b0;
    vectors++;
    if (t0 < 0 || t1 < 0 || t1 - t0 !== 9) begin
      miscompares++;
      $display("FAIL b2b_spacing: done at %0d and %0d, want 9 apart", t0, t1);
    end
    vectors++;
    if (r0 !== {8'h06, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_first: diff/borrow=%h want 00c", r0);
    end
    vectors++;
    if (r1 !== {8'hFA, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_second: diff/borrow=%h want 1f5", r1);
    end
    repeat (12) tick();
  endtask

  task automatic test_width1();
    logic [1:0] exp_db [4] = '{2'b00, 2'b11, 2'b10, 2'b00};
    for (int k = 0; k < 4; k++) begin
      {a1, b1} = 2'(k);
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      vectors++;
      if ({busy1, done1} !== 2'b10) begin
        miscompares++;
        $display("FAIL w1_busy k=%0d: busy=%b done=%b want 1/0", k, busy1, done1);
      end
      tick();
      vectors++;
      if ({done1, diff1, borrow1} !== {1'b1, exp_db[k]}) begin
        miscompares++;
        $display("FAIL w1_result k=%0d: done=%b diff=%b borrow=%b want 1/%b", k, done1, diff1, borrow1, exp_db[k]);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underflow();
    test_ignore_start();
    test_reset_midrun();
    test_back_to_back();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
